mem_bus_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: instruction fetch (master 0, read-only) and load/store (master 1, read/write).
- Sits between the IFU/MEM units and the memory model in the multi-cycle core.
- Arbitrates, latches one transaction, drives it to the slave, routes the response back, and raises an error on response timeout.
- Exactly one transaction is outstanding at any time.

---
 rtl/mem_bus_arbiter_if.sv | 50 +++++
 rtl/mem_bus_arbiter.sv | 104 ++++++++++
 tb/tb_mem_bus_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - shared memory port bundle: IFU, LSU, arbiter and memory slave
interface mem_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            m0_req_valid;
  logic            m0_req_ready;
  logic [AW-1:0]   m0_addr;
  logic            m0_resp_valid;
  logic [DW-1:0]   m0_rdata;
  logic            m0_resp_err;

  logic            m1_req_valid;
  logic            m1_req_ready;
  logic [AW-1:0]   m1_addr;
  logic            m1_wen;
  logic [DW-1:0]   m1_wdata;
  logic [DW/8-1:0] m1_wstrb;
  logic            m1_resp_valid;
  logic [DW-1:0]   m1_rdata;
  logic            m1_resp_err;

  logic            s_req_valid;
  logic            s_req_ready;
  logic [AW-1:0]   s_addr;
  logic            s_wen;
  logic [DW-1:0]   s_wdata;
  logic [DW/8-1:0] s_wstrb;
  logic            s_resp_valid;
  logic [DW-1:0]   s_rdata;

  // master is the arbiter's view; slave is the requesters and memory around it
  modport master (
    input  m0_req_valid, m0_addr,
    input  m1_req_valid, m1_addr, m1_wen, m1_wdata, m1_wstrb,
    input  s_req_ready, s_resp_valid, s_rdata,
    output m0_req_ready, m0_resp_valid, m0_rdata, m0_resp_err,
    output m1_req_ready, m1_resp_valid, m1_rdata, m1_resp_err,
    output s_req_valid, s_addr, s_wen, s_wdata, s_wstrb
  );

  modport slave (
    output m0_req_valid, m0_addr,
    output m1_req_valid, m1_addr, m1_wen, m1_wdata, m1_wstrb,
    output s_req_ready, s_resp_valid, s_rdata,
    input  m0_req_ready, m0_resp_valid, m0_rdata, m0_resp_err,
    input  m1_req_ready, m1_resp_valid, m1_rdata, m1_resp_err,
    input  s_req_valid, s_addr, s_wen, s_wdata, s_wstrb
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master single-outstanding arbiter for the data-memory port
// IFU (m0, read-only) and LSU (m1) share one slave; one transaction in flight, optional timeout.
module mem_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RR      = 0,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  mem_bus_arbiter_if.master  bus,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TW-1:0] TO_LAST_W = TW'(TO_LAST);

  state_t          state;
  logic            grant;
  logic            last_grant;
  logic [TW-1:0]   tcnt;
  logic [AW-1:0]   s_addr_q;
  logic            s_wen_q;
  logic [DW-1:0]   s_wdata_q;
  logic [DW/8-1:0] s_wstrb_q;

  logic any_valid;
  logic winner;
  logic in_resp;
  logic timeout_hit;
  logic resp_hit;

  always_comb begin
    any_valid = bus.m0_req_valid | bus.m1_req_valid;
    winner    = bus.m1_req_valid;
    if (bus.m0_req_valid && bus.m1_req_valid && RR != 0)
      winner = ~last_grant;
    in_resp     = (state == RESP) && !rst;
    // a real response in the last allowed cycle beats the timeout
    timeout_hit = (TIMEOUT != 0) && in_resp && !bus.s_resp_valid && (tcnt == TO_LAST_W);
    resp_hit    = in_resp && (bus.s_resp_valid || timeout_hit);
  end

  assign bus.m0_req_ready  = (state == IDLE) && !rst && any_valid && !winner;
  assign bus.m1_req_ready  = (state == IDLE) && !rst && winner;

  assign bus.m0_resp_valid = resp_hit && !grant;
  assign bus.m0_resp_err   = timeout_hit && !grant;
  assign bus.m0_rdata      = (in_resp && !grant && !timeout_hit) ? bus.s_rdata : '0;
  assign bus.m1_resp_valid = resp_hit && grant;
  assign bus.m1_resp_err   = timeout_hit && grant;
  assign bus.m1_rdata      = (in_resp && grant && !timeout_hit) ? bus.s_rdata : '0;

  assign bus.s_req_valid   = (state == REQ);
  assign bus.s_addr        = s_addr_q;
  assign bus.s_wen         = s_wen_q;
  assign bus.s_wdata       = s_wdata_q;
  assign bus.s_wstrb       = s_wstrb_q;
  assign busy              = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b0;
      tcnt       <= '0;
      s_addr_q   <= '0;
      s_wen_q    <= 1'b0;
      s_wdata_q  <= '0;
      s_wstrb_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant      <= winner;
            last_grant <= winner;
            s_addr_q   <= winner ? bus.m1_addr : bus.m0_addr;
            s_wen_q    <= winner && bus.m1_wen;
            s_wdata_q  <= winner ? bus.m1_wdata : '0;
            s_wstrb_q  <= (winner && bus.m1_wen) ? bus.m1_wstrb : '0;
            state      <= REQ;
          end
        end
        REQ: begin
          if (bus.s_req_ready) begin
            tcnt  <= '0;
            state <= RESP;
          end
        end
        RESP: begin
          if (bus.s_resp_valid || timeout_hit)
            state <= IDLE;
          else if (TIMEOUT != 0)
            tcnt <= tcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench: dut0 RR=0/TIMEOUT=4, dut1 RR=1/TIMEOUT=3 on shared stimulus
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m0_req_valid;
  logic [31:0] m0_addr;
  logic        m1_req_valid;
  logic [31:0] m1_addr;
  logic        m1_wen;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wstrb;
  logic        s_req_ready;
  logic        s_resp_valid;
  logic [31:0] s_rdata;

  logic        m0_rdy [2], m1_rdy [2], m0_rv [2], m1_rv [2], m0_err [2], m1_err [2];
  logic        s_rv [2], s_wen_o [2], busy_o [2];
  logic [31:0] m0_rd [2], m1_rd [2], s_addr_o [2], s_wdata_o [2];
  logic [3:0]  s_wstrb_o [2];

  int total = 0;
  int bad = 0;

  mem_bus_arbiter_if #(.AW(32), .DW(32)) bus [2] ();

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign bus[g].m0_req_valid = m0_req_valid;
    assign bus[g].m0_addr      = m0_addr;
    assign bus[g].m1_req_valid = m1_req_valid;
    assign bus[g].m1_addr      = m1_addr;
    assign bus[g].m1_wen       = m1_wen;
    assign bus[g].m1_wdata     = m1_wdata;
    assign bus[g].m1_wstrb     = m1_wstrb;
    assign bus[g].s_req_ready  = s_req_ready;
    assign bus[g].s_resp_valid = s_resp_valid;
    assign bus[g].s_rdata      = s_rdata;
    assign m0_rdy[g]    = bus[g].m0_req_ready;
    assign m1_rdy[g]    = bus[g].m1_req_ready;
    assign m0_rv[g]     = bus[g].m0_resp_valid;
    assign m1_rv[g]     = bus[g].m1_resp_valid;
    assign m0_err[g]    = bus[g].m0_resp_err;
    assign m1_err[g]    = bus[g].m1_resp_err;
    assign m0_rd[g]     = bus[g].m0_rdata;
    assign m1_rd[g]     = bus[g].m1_rdata;
    assign s_rv[g]      = bus[g].s_req_valid;
    assign s_wen_o[g]   = bus[g].s_wen;
    assign s_addr_o[g]  = bus[g].s_addr;
    assign s_wdata_o[g] = bus[g].s_wdata;
    assign s_wstrb_o[g] = bus[g].s_wstrb;

    mem_bus_arbiter #(.AW(32), .DW(32), .RR(g), .TIMEOUT((g == 0) ? 4 : 3)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus[g]),
      .busy (busy_o[g])
    );
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m0_req_valid = 0; m0_addr = '0; m1_req_valid = 0; m1_addr = '0; m1_wen = 0;
    m1_wdata = '0; m1_wstrb = '0; s_req_ready = 0; s_resp_valid = 0; s_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cyc();
    cyc();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    smp();
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({m0_rdy[d], m1_rdy[d], m0_rv[d], m1_rv[d], m0_err[d], m1_err[d], s_rv[d], s_wen_o[d], busy_o[d]} !== 9'b0) begin
        bad++; $display("FAIL reset_ctrl dut%0d got %b want 0", d,
          {m0_rdy[d], m1_rdy[d], m0_rv[d], m1_rv[d], m0_err[d], m1_err[d], s_rv[d], s_wen_o[d], busy_o[d]});
      end
      total++;
      if ({m0_rd[d], m1_rd[d], s_addr_o[d], s_wdata_o[d], s_wstrb_o[d]} !== 132'b0) begin
        bad++; $display("FAIL reset_data dut%0d got %h want 0", d, {m0_rd[d], m1_rd[d], s_addr_o[d], s_wdata_o[d], s_wstrb_o[d]});
      end
    end
  endtask

  task automatic test_ifu_read();
    do_reset();
    m0_req_valid = 1; m0_addr = 32'h8000_0000; m1_addr = 32'h5555_0000;
    smp();
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({m0_rdy[d], m1_rdy[d]} !== 2'b10) begin bad++; $display("FAIL ifu_grant dut%0d got %b want 10", d, {m0_rdy[d], m1_rdy[d]}); end
    end
    cyc(); m0_req_valid = 0; m0_addr = '0; s_req_ready = 1;
    smp();
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({s_rv[d], s_wen_o[d], busy_o[d], s_wstrb_o[d], s_addr_o[d]} !== {3'b101, 4'h0, 32'h8000_0000}) begin
        bad++; $display("FAIL ifu_req dut%0d got %h want %h", d, {s_rv[d], s_wen_o[d], busy_o[d], s_wstrb_o[d], s_addr_o[d]},
          {3'b101, 4'h0, 32'h8000_0000});
      end
    end
    cyc(); s_req_ready = 0; s_resp_valid = 1; s_rdata = 32'h0000_0413;
    smp();
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({m0_rv[d], m0_err[d], m1_rv[d], m1_err[d], m0_rd[d], m1_rd[d]} !== {4'b1000, 32'h0000_0413, 32'h0}) begin
        bad++; $display("FAIL ifu_resp dut%0d got %h want %h", d, {m0_rv[d], m0_err[d], m1_rv[d], m1_err[d], m0_rd[d], m1_rd[d]},
          {4'b1000, 32'h0000_0413, 32'h0});
      end
    end
    cyc(); s_resp_valid = 0;
    smp();
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({busy_o[d], m0_rv[d]} !== 2'b00) begin bad++; $display("FAIL ifu_done dut%0d got %b want 00", d, {busy_o[d], m0_rv[d]}); end
    end
  endtask

  task automatic test_lsu_write();
    int pulses [2];
    int errs [2];
    do_reset();
    m1_req_valid = 1; m1_addr = 32'h8000_1000; m1_wen = 1; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'hF;
    smp();
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({m0_rdy[d], m1_rdy[d]} !== 2'b01) begin bad++; $display("FAIL lsu_grant dut%0d got %b want 01", d, {m0_rdy[d], m1_rdy[d]}); end
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 0) begin m1_req_valid = 0; m1_addr = 32'h1; m1_wdata = 32'h2; m1_wstrb = 4'h3; m1_wen = 0; end
      s_req_ready = (i == 3);
      smp();
      for (int d = 0; d < 2; d++) begin
        total++;
        if ({s_rv[d], s_wen_o[d], s_addr_o[d], s_wdata_o[d], s_wstrb_o[d], m1_rv[d]} !== {2'b11, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 1'b0}) begin
          bad++; $display("FAIL lsu_hold%0d dut%0d got %h want %h", i, d, {s_rv[d], s_wen_o[d], s_addr_o[d], s_wdata_o[d], s_wstrb_o[d], m1_rv[d]},
            {2'b11, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 1'b0});
        end
      end
    end
    pulses[0] = 0; pulses[1] = 0; errs[0] = 0; errs[1] = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(); s_req_ready = 0; s_resp_valid = (i == 0);
      smp();
      for (int d = 0; d < 2; d++) begin
        pulses[d] += int'(m1_rv[d]) + int'(m0_rv[d]);
        errs[d]   += int'(m1_err[d]) + int'(m0_err[d]);
      end
    end
    s_resp_valid = 0;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (pulses[d] != 1 || errs[d] != 0) begin bad++; $display("FAIL lsu_resp dut%0d got pulses=%0d errs=%0d want 1/0", d, pulses[d], errs[d]); end
    end
  endtask

  task automatic test_contention();
    logic e [2];
    int last_rr;
    do_reset();
    last_rr = 0;
    m0_req_valid = 1; m1_req_valid = 1; m0_addr = 32'h100; m1_addr = 32'h200;
    s_req_ready = 1; s_resp_valid = 1; s_rdata = 32'hCAFE_0000;
    for (int k = 0; k < 4; k++) begin
      e[0] = 1'b1;
      e[1] = (last_rr == 0);
      last_rr = e[1] ? 1 : 0;
      smp();
      for (int d = 0; d < 2; d++) begin
        total++;
        if ({m1_rdy[d], m0_rdy[d]} !== {e[d], !e[d]}) begin
          bad++; $display("FAIL cont_grant%0d dut%0d got %b want %b", k, d, {m1_rdy[d], m0_rdy[d]}, {e[d], !e[d]});
        end
      end
      cyc(); smp();
      for (int d = 0; d < 2; d++) begin
        total++;
        if ({s_addr_o[d], m1_rdy[d], m0_rdy[d]} !== {(e[d] ? 32'h200 : 32'h100), 2'b00}) begin
          bad++; $display("FAIL cont_req%0d dut%0d got %h want %h", k, d, {s_addr_o[d], m1_rdy[d], m0_rdy[d]}, {(e[d] ? 32'h200 : 32'h100), 2'b00});
        end
      end
      cyc(); smp();
      for (int d = 0; d < 2; d++) begin
        total++;
        if ({m1_rv[d], m0_rv[d], m1_rdy[d], m0_rdy[d]} !== {e[d], !e[d], 2'b00}) begin
          bad++; $display("FAIL cont_resp%0d dut%0d got %b want %b", k, d, {m1_rv[d], m0_rv[d], m1_rdy[d], m0_rdy[d]}, {e[d], !e[d], 2'b00});
        end
      end
      cyc();
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    int to;
    logic xv, xb;
    do_reset();
    m0_req_valid = 1; m0_addr = 32'h8000_0040;
    smp();
    cyc(); m0_req_valid = 0; s_req_ready = 1;
    smp();
    for (int c = 1; c <= 6; c++) begin
      cyc(); s_req_ready = 0; s_rdata = 32'hFFFF_FFFF; s_resp_valid = (c == 6);
      smp();
      for (int d = 0; d < 2; d++) begin
        to = (d == 0) ? 4 : 3;
        xv = (c == to);
        xb = (c <= to);
        total++;
        if ({m0_rv[d], m0_err[d], busy_o[d], m1_rv[d], m0_rd[d]} !== {xv, xv, xb, 1'b0, ((c < to) ? 32'hFFFF_FFFF : 32'h0)}) begin
          bad++; $display("FAIL timeout_c%0d dut%0d got %h want %h", c, d, {m0_rv[d], m0_err[d], busy_o[d], m1_rv[d], m0_rd[d]},
            {xv, xv, xb, 1'b0, ((c < to) ? 32'hFFFF_FFFF : 32'h0)});
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_simul_resp_timeout();
    do_reset();
    m1_req_valid = 1; m1_addr = 32'h8000_2000; m1_wen = 0; m1_wstrb = 4'hF; m1_wdata = 32'h7777_7777;
    smp();
    cyc(); m1_req_valid = 0; s_req_ready = 1;
    smp();
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({s_wen_o[d], s_wstrb_o[d], s_addr_o[d]} !== {1'b0, 4'h0, 32'h8000_2000}) begin
        bad++; $display("FAIL read_strb dut%0d got %h want %h", d, {s_wen_o[d], s_wstrb_o[d], s_addr_o[d]}, {1'b0, 4'h0, 32'h8000_2000});
      end
    end
    for (int c = 1; c <= 3; c++) begin
      cyc(); s_req_ready = 0; s_resp_valid = (c == 3); s_rdata = 32'h1234_5678;
      smp();
      for (int d = 0; d < 2; d++) begin
        total++;
        if ({m1_rv[d], m1_err[d], m1_rd[d]} !== {(c == 3), 1'b0, 32'h1234_5678}) begin
          bad++; $display("FAIL simul_c%0d dut%0d got %h want %h", c, d, {m1_rv[d], m1_err[d], m1_rd[d]}, {(c == 3), 1'b0, 32'h1234_5678});
        end
      end
    end
    cyc(); s_resp_valid = 0;
    smp();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (busy_o[d] !== 1'b0) begin bad++; $display("FAIL simul_idle dut%0d got %b want 0", d, busy_o[d]); end
    end
  endtask

  task automatic test_reset_in_resp();
    do_reset();
    m1_req_valid = 1; m1_addr = 32'h8000_3000; m1_wen = 0;
    smp();
    cyc(); m1_req_valid = 0; s_req_ready = 1;
    cyc(); s_req_ready = 0;
    smp();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (busy_o[d] !== 1'b1) begin bad++; $display("FAIL rst_pre dut%0d got %b want 1", d, busy_o[d]); end
    end
    cyc(); rst = 1;
    cyc(); rst = 0;
    smp();
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({m0_rdy[d], m1_rdy[d], m0_rv[d], m1_rv[d], m0_err[d], m1_err[d], s_rv[d], s_wen_o[d], busy_o[d], s_addr_o[d], m1_rd[d]} !== 73'b0) begin
        bad++; $display("FAIL rst_outputs dut%0d got %h want 0", d,
          {m0_rdy[d], m1_rdy[d], m0_rv[d], m1_rv[d], m0_err[d], m1_err[d], s_rv[d], s_wen_o[d], busy_o[d], s_addr_o[d], m1_rd[d]});
      end
    end
    cyc(); s_resp_valid = 1; s_rdata = 32'hAAAA_5555;
    smp();
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({m0_rv[d], m1_rv[d], m0_err[d], m1_err[d], m0_rd[d], m1_rd[d]} !== 68'b0) begin
        bad++; $display("FAIL rst_stray dut%0d got %h want 0", d, {m0_rv[d], m1_rv[d], m0_err[d], m1_err[d], m0_rd[d], m1_rd[d]});
      end
    end
    cyc(); s_resp_valid = 0; m0_req_valid = 1; m0_addr = 32'h8000_0080;
    smp();
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({m0_rdy[d], m1_rdy[d]} !== 2'b10) begin bad++; $display("FAIL rst_regrant dut%0d got %b want 10", d, {m0_rdy[d], m1_rdy[d]}); end
    end
    cyc(); m0_req_valid = 0; s_req_ready = 1;
    cyc(); s_req_ready = 0; s_resp_valid = 1; s_rdata = 32'h0000_0013;
    smp();
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({m0_rv[d], m0_err[d], m0_rd[d], s_addr_o[d]} !== {2'b10, 32'h0000_0013, 32'h8000_0080}) begin
        bad++; $display("FAIL rst_newresp dut%0d got %h want %h", d, {m0_rv[d], m0_err[d], m0_rd[d], s_addr_o[d]}, {2'b10, 32'h0000_0013, 32'h8000_0080});
      end
    end
    cyc(); idle_inputs();
  endtask

  task automatic test_back_to_back_random();
    logic        w [2];
    logic        v0, v1, wen, hit;
    logic [31:0] a0, a1, wd, sr;
    logic [3:0]  ws;
    int          v, stall, lat, last_b;
    do_reset();
    last_b = 0;
    for (int n = 0; n < 40; n++) begin
      v = $urandom_range(1, 3);
      v0 = v[0]; v1 = v[1];
      a0 = $urandom; a1 = $urandom; wen = 1'($urandom_range(0, 1)); wd = $urandom; ws = 4'($urandom_range(0, 15));
      stall = $urandom_range(0, 2); lat = $urandom_range(0, 2);
      m0_req_valid = v0; m0_addr = a0; m1_req_valid = v1; m1_addr = a1; m1_wen = wen; m1_wdata = wd; m1_wstrb = ws;
      // fixed priority always favours the LSU; round-robin flips only on contention
      w[0] = v1;
      w[1] = (v0 && v1) ? (last_b == 0) : v1;
      last_b = w[1] ? 1 : 0;
      smp();
      for (int d = 0; d < 2; d++) begin
        total++;
        if ({m1_rdy[d], m0_rdy[d]} !== {w[d], !w[d]}) begin
          bad++; $display("FAIL rnd_grant%0d dut%0d got %b want %b", n, d, {m1_rdy[d], m0_rdy[d]}, {w[d], !w[d]});
        end
      end
      for (int i = 0; i <= stall; i++) begin
        cyc();
        if (i == 0) begin
          m0_req_valid = 0; m1_req_valid = 0; m0_addr = $urandom; m1_addr = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom_range(0, 15));
        end
        s_req_ready = (i == stall);
        smp();
        for (int d = 0; d < 2; d++) begin
          total++;
          if ({s_rv[d], s_addr_o[d], s_wen_o[d], s_wstrb_o[d]} !== {1'b1, (w[d] ? a1 : a0), (w[d] && wen), ((w[d] && wen) ? ws : 4'h0)}) begin
            bad++; $display("FAIL rnd_req%0d dut%0d got %h want %h", n, d, {s_rv[d], s_addr_o[d], s_wen_o[d], s_wstrb_o[d]},
              {1'b1, (w[d] ? a1 : a0), (w[d] && wen), ((w[d] && wen) ? ws : 4'h0)});
          end
          if (w[d]) begin
            total++;
            if (s_wdata_o[d] !== wd) begin bad++; $display("FAIL rnd_wdata%0d dut%0d got %h want %h", n, d, s_wdata_o[d], wd); end
          end
        end
      end
      for (int i = 0; i <= lat; i++) begin
        cyc();
        s_req_ready = 0; hit = (i == lat); s_resp_valid = hit; sr = $urandom; s_rdata = sr;
        smp();
        for (int d = 0; d < 2; d++) begin
          total++;
          if ({m0_rv[d], m1_rv[d], m0_err[d], m1_err[d], m0_rd[d], m1_rd[d]} !==
              {(hit && !w[d]), (hit && w[d]), 2'b00, (w[d] ? 32'h0 : sr), (w[d] ? sr : 32'h0)}) begin
            bad++; $display("FAIL rnd_resp%0d dut%0d got %h want %h", n, d, {m0_rv[d], m1_rv[d], m0_err[d], m1_err[d], m0_rd[d], m1_rd[d]},
              {(hit && !w[d]), (hit && w[d]), 2'b00, (w[d] ? 32'h0 : sr), (w[d] ? sr : 32'h0)});
          end
        end
      end
      cyc();
      s_resp_valid = 0;
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_ifu_read();
    test_lsu_write();
    test_contention();
    test_timeout();
    test_simul_resp_timeout();
    test_reset_in_resp();
    test_back_to_back_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
